// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from N_REQ requesters to one UART transmitter.
//
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   req, req_data       : per-requester level request and packed bytes (slice i = [i*NB_DATA +: NB_DATA])
//   ack, done           : one-hot pulses: byte latched / byte finished transmitting
//   busy                : high whenever the arbiter is not idle
//   timeout             : one-cycle pulse when the watchdog aborts a transfer
//   din, tx_start       : byte and start pulse to the transmitter
//   tx_done_tick        : end-of-frame pulse from the transmitter
//
// Build option: define UART_TX_ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES); otherwise timeout is tied to 0 and BUSY waits forever.
module uart_tx_arbiter #(
    parameter int NB_DATA        = 8,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*NB_DATA-1:0] req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     timeout,
    output logic [NB_DATA-1:0]       din,
    output logic                     tx_start,
    input  logic                     tx_done_tick
);
    localparam int LW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t        state;
    logic [LW-1:0] cur;
    logic [LW-1:0] last_grant;
    logic [LW-1:0] sel;

    // Walk downward so the requester closest above last_grant wins.
    always_comb begin
        sel = last_grant;
        for (int i = N_REQ; i >= 1; i--)
            if (req[(int'(last_grant) + i) % N_REQ]) sel = LW'((int'(last_grant) + i) % N_REQ);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= LW'(N_REQ - 1);
            din        <= '0;
            ack        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            tx_start   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout    <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: if (|req) begin
                    state      <= START;
                    din        <= req_data[sel*NB_DATA +: NB_DATA];
                    cur        <= sel;
                    last_grant <= sel;
                    ack        <= N_REQ'(1) << sel;
                    tx_start   <= 1'b1;
                    busy       <= 1'b1;
                end
                START: begin
                    state    <= BUSY;
                    ack      <= '0;
                    tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                BUSY: begin
                    // A frame end in the expiry cycle still counts as success.
                    if (tx_done_tick) begin
                        state <= DONE;
                        done  <= N_REQ'(1) << cur;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus hand sequences for uart_tx_arbiter.
module tb_uart_tx_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        tx_done_tick = 1'b0;
    logic [3:0]  ack, done;
    logic        busy, timeout, tx_start;
    logic [7:0]  din;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NB_DATA(8), .N_REQ(4), .TIMEOUT_CYCLES(50)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .busy(busy), .timeout(timeout),
        .din(din), .tx_start(tx_start), .tx_done_tick(tx_done_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        tdt;
        logic [3:0]  ack;
        logic [3:0]  done;
        logic        busy;
        logic        txs;
        logic [7:0]  din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] rq, logic [31:0] d, logic tdt,
                                logic [3:0] a, logic [3:0] dn, logic b, logic t, logic [7:0] di);
        vec_t v;
        v.rst = rst; v.req = rq; v.data = d; v.tdt = tdt;
        v.ack = a; v.done = dn; v.busy = b; v.txs = t; v.din = di;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [31:0] RR = 32'h43322110;

    initial begin
        logic [7:0] rr_b;
        logic [31:0] rr_w;
        rr_w = RR;
        // reset, single request, tx_done_tick ignored in START/DONE, stray tick in IDLE
        tbl.push_back(mk(1, 4'b0000, 32'h0,  0, 4'b0000, 4'b0000, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 32'hAB, 0, 4'b0001, 4'b0000, 1, 1, 8'hAB));
        tbl.push_back(mk(0, 4'b0000, 32'hAB, 1, 4'b0000, 4'b0000, 1, 0, 8'hAB));
        tbl.push_back(mk(0, 4'b0000, 32'hAB, 0, 4'b0000, 4'b0000, 1, 0, 8'hAB));
        tbl.push_back(mk(0, 4'b0000, 32'hAB, 1, 4'b0000, 4'b0001, 1, 0, 8'hAB));
        tbl.push_back(mk(0, 4'b0000, 32'hAB, 1, 4'b0000, 4'b0000, 0, 0, 8'hAB));
        tbl.push_back(mk(0, 4'b0000, 32'hAB, 1, 4'b0000, 4'b0000, 0, 0, 8'hAB));
        // round robin with all four held: grants 0,1,2,3,0
        tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            rr_b = rr_w[g*8 +: 8];
            tbl.push_back(mk(0, 4'b1111, RR, 0, 4'(1 << g), 4'b0000, 1, 1, rr_b));
            tbl.push_back(mk(0, 4'b1111, RR, 0, 4'b0000, 4'b0000, 1, 0, rr_b));
            tbl.push_back(mk(0, 4'b1111, RR, 1, 4'b0000, 4'(1 << g), 1, 0, rr_b));
            tbl.push_back(mk(0, 4'b1111, RR, 0, 4'b0000, 4'b0000, 0, 0, rr_b));
        end

        foreach (tbl[i]) begin
            reset = tbl[i].rst; req = tbl[i].req; req_data = tbl[i].data; tx_done_tick = tbl[i].tdt;
            tick();
            chk($sformatf("vec%0d.ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(tbl[i].txs));
            chk($sformatf("vec%0d.din", i), 32'(din), 32'(tbl[i].din));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'd0);
        end

        // single request with a 20-cycle frame, late requests during BUSY
        reset = 1; req = 0; tx_done_tick = 0; tick();
        reset = 0; req = 4'b0001; req_data = 32'h005C00AB; tick();
        chk("single.tx_start", 32'(tx_start), 32'd1);
        chk("single.ack", 32'(ack), 32'b0001);
        chk("single.din", 32'(din), 32'hAB);
        req = 4'b0110;
        for (int i = 1; i <= 19; i++) begin
            if (i == 5) req = 4'b0100;
            tick();
            chk("late.ack_wait", 32'(ack), 32'd0);
            chk("late.busy_wait", 32'(busy), 32'd1);
            chk("late.din_stable", 32'(din), 32'hAB);
        end
        tx_done_tick = 1; tick();
        chk("single.done", 32'(done), 32'b0001);
        chk("single.busy_done", 32'(busy), 32'd1);
        tx_done_tick = 0; tick();
        chk("single.busy_fall", 32'(busy), 32'd0);
        chk("single.done_clear", 32'(done), 32'd0);
        chk("late.ack_idle", 32'(ack), 32'd0);
        tick();
        chk("late.ack", 32'(ack), 32'b0100);
        chk("late.din", 32'(din), 32'h5C);
        chk("late.tx_start", 32'(tx_start), 32'd1);

        // reset mid-transfer, then priority restarts at requester 0
        req = 0; tick();
        chk("rst.busy_before", 32'(busy), 32'd1);
        reset = 1; tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.tx_start", 32'(tx_start), 32'd0);
        chk("rst.din", 32'(din), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        reset = 0; req = 4'b1001; req_data = 32'h770000AB; tick();
        chk("rst.ack_prio", 32'(ack), 32'b0001);
        chk("rst.din_prio", 32'(din), 32'hAB);

        // watchdog: no tx_done_tick ever arrives
        req = 0; tick();
        for (int n = 1; n <= 60; n++) begin
            tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
            chk($sformatf("wd.timeout%0d", n), 32'(timeout), 32'(n == 50));
            chk($sformatf("wd.busy%0d", n), 32'(busy), 32'(n < 50));
`else
            chk($sformatf("wd.timeout%0d", n), 32'(timeout), 32'd0);
            chk($sformatf("wd.busy%0d", n), 32'(busy), 32'd1);
`endif
            chk($sformatf("wd.done%0d", n), 32'(done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the width of each transmit byte.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; legal values are 2, 4 and 8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the watchdog limit in clock cycles (used only under REQ-026).
REQ-004 Port clock, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req, input, N_REQ bits: per-requester level request; bit i high means requester i has a byte pending.
REQ-007 Port req_data, input, N_REQ*NB_DATA bits: packed bytes; slice i occupies bits [i*NB_DATA +: NB_DATA].
REQ-008 Port ack, output, N_REQ bits: one-hot pulse confirming that the byte from requester i was latched.
REQ-009 Port done, output, N_REQ bits: one-hot pulse confirming that the byte from requester i finished transmitting.
REQ-010 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port timeout, output, 1 bit: one-cycle pulse when the watchdog aborts a transfer.
REQ-012 Port din, output, NB_DATA bits: byte driven to the transmitter.
REQ-013 Port tx_start, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-014 Port tx_done_tick, input, 1 bit: end-of-frame pulse from the transmitter.

Function
REQ-015 The state machine SHALL have four states, IDLE, START, BUSY and DONE, with every output registered.
REQ-016 In IDLE with req nonzero, the block SHALL perform the following in one cycle:
- select requester sel by round-robin, searching upward from (last_grant+1) mod N_REQ;
- latch req_data slice sel into din;
- record sel as cur and as last_grant;
- move to START.
REQ-017 In START, which lasts exactly one cycle, tx_start SHALL be 1 and ack[cur] SHALL be 1; the state then moves to BUSY.
REQ-018 In BUSY, tx_start SHALL be 0 and din SHALL remain stable; on tx_done_tick=1 the state moves to DONE.
REQ-019 In DONE, which lasts exactly one cycle, done[cur] SHALL be 1; the state then moves to IDLE.
REQ-020 Latency from req sampled in IDLE to tx_start high SHALL be 1 cycle, and from tx_done_tick to done high SHALL be 1 cycle.
REQ-021 tx_done_tick SHALL be ignored in IDLE, START and DONE.
REQ-022 Handshake rules for requesters:
- A requester SHALL hold req and req_data stable until it sees ack.
- After ack, it may change req_data or drop req.
- A req dropped before grant SHALL receive neither ack nor done.
REQ-023 Requests arriving while busy=1 SHALL wait; arbitration occurs only in IDLE, so the minimum period between consecutive tx_start pulses is 4 cycles plus the frame time.
REQ-024 Simultaneous requests SHALL be served one per transfer in round-robin order, so that no requester is granted twice while another requester holds req continuously.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL enter IDLE and clear outputs and internal state as follows, including when reset is asserted mid-transfer:
- ack, done, timeout, tx_start and busy SHALL be 0;
- din SHALL be 0;
- cur SHALL be 0;
- last_grant SHALL be N_REQ-1, so requester 0 has first priority.

Configuration
REQ-026 With macro UART_TX_ARB_TIMEOUT_EN defined, the watchdog SHALL operate as follows:
- a counter clears on entry to BUSY and increments every cycle in BUSY;
- if it reaches TIMEOUT_CYCLES without tx_done_tick, the block pulses timeout for 1 cycle, returns directly to IDLE, and does not assert done;
- if tx_done_tick and expiry occur in the same cycle, tx_done_tick wins.
REQ-027 Without UART_TX_ARB_TIMEOUT_EN, the block SHALL contain no counter, SHALL tie timeout to constant 0, and SHALL wait in BUSY indefinitely; the port list is identical in both builds.

Verification
REQ-028 Single request: req=4'b0001 with slice0=8'hAB, followed by tx_done_tick 20 cycles after tx_start -> one cycle later din=8'hAB, tx_start=1 and ack=4'b0001; done=4'b0001 one cycle after tx_done_tick; busy falls one cycle after that.
REQ-029 Round-robin: req=4'b1111 held, with slices 8'h10, 8'h21, 8'h32 and 8'h43 -> grants in order 0, 1, 2, 3, 0, and din follows the same sequence.
REQ-030 Late request: req=4'b0100 asserted during requester 0's BUSY -> no ack until DONE->IDLE; requester 2 is granted on the first IDLE cycle.
REQ-031 Reset during BUSY: reset for 1 cycle -> the next cycle shows busy=0, tx_start=0, din=0 and no done; a subsequent req=4'b1000 with req=4'b0001 together grants requester 0 first.
REQ-032 Stray tx_done_tick in IDLE with req=0 -> no done, busy stays 0.
REQ-033 Watchdog, with UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50: tx_done_tick is never sent -> timeout pulses 50 cycles after BUSY entry, the state returns to IDLE, and done stays 0. Without the macro, the same stimulus leaves busy=1 indefinitely.
